// File: rtl/bfp_prb_unpack.sv
// O-RAN block-floating-point PUSCH unpacker: exponent byte + 21 packed bytes per PRB
// become 12 registered RE samples (I/Q, MSB first) with PRB/symbol framing.
module bfp_prb_unpack #(
    parameter int SHIFT_WIDTH = 4,
    parameter int DATA_WIDTH  = 7,
    parameter int RE_PER_PRB  = 12,
    parameter int PRB_NUM     = 273
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             i_byte,
    input  logic                   i_vld,
    input  logic                   i_sop,
    output logic [SHIFT_WIDTH-1:0] o_agc,
    output logic [DATA_WIDTH-1:0]  o_dout_i,
    output logic [DATA_WIDTH-1:0]  o_dout_q,
    output logic                   o_vld,
    output logic                   o_sop,
    output logic                   o_eop,
    output logic [8:0]             o_prb_idx,
    output logic                   o_err
);

    localparam int RE_BITS       = 2 * DATA_WIDTH;
    localparam int HOLD_W        = RE_BITS - 1;
    localparam int ACC_W         = HOLD_W + 8;
    localparam int CNT_W         = $clog2(ACC_W + 1);
    localparam int BYTES_PER_PRB = RE_PER_PRB * RE_BITS / 8;
    localparam int BYTE_W        = $clog2(BYTES_PER_PRB);
    localparam int RE_W          = $clog2(RE_PER_PRB);
    localparam int PRB_W         = 9;
    localparam logic [SHIFT_WIDTH-1:0] AGC_MAX = SHIFT_WIDTH'(9);

    typedef enum logic [1:0] {
        IDLE,
        EXP,
        DATA
    } state_t;

    state_t                 state_q, state_d;
    logic [SHIFT_WIDTH-1:0] agc_q, agc_d;
    logic [HOLD_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BYTE_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [RE_W-1:0]        re_cnt_q, re_cnt_d;
    logic [PRB_W-1:0]       prb_q, prb_d;

    logic [SHIFT_WIDTH-1:0] out_agc_q, out_agc_d;
    logic [DATA_WIDTH-1:0]  out_i_q, out_i_d;
    logic [DATA_WIDTH-1:0]  out_q_q, out_q_d;
    logic                   out_vld_q, out_vld_d;
    logic                   out_sop_q, out_sop_d;
    logic                   out_eop_q, out_eop_d;
    logic [PRB_W-1:0]       out_prb_q, out_prb_d;
    logic                   out_err_q, out_err_d;

    logic [ACC_W-1:0]       acc_app;
    logic [CNT_W-1:0]       cnt_app;
    logic [RE_BITS-1:0]     re_bits;

    // Held bits are always LSB-aligned, so the oldest RE sits just below the occupancy mark.
    always_comb begin
        acc_app = {acc_q, i_byte};
        cnt_app = cnt_q + CNT_W'(8);
        re_bits = RE_BITS'(acc_app >> (cnt_app - CNT_W'(RE_BITS)));

        state_d    = state_q;
        agc_d      = agc_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        re_cnt_d   = re_cnt_q;
        prb_d      = prb_q;
        out_agc_d  = out_agc_q;
        out_i_d    = out_i_q;
        out_q_d    = out_q_q;
        out_prb_d  = out_prb_q;
        out_vld_d  = 1'b0;
        out_sop_d  = 1'b0;
        out_eop_d  = 1'b0;
        out_err_d  = 1'b0;

        if (i_vld && i_sop) begin
            // Any sop restarts the symbol; outside IDLE it also flags the truncation.
            out_err_d  = (state_q != IDLE) || (i_byte[SHIFT_WIDTH-1:0] > AGC_MAX);
            agc_d      = i_byte[SHIFT_WIDTH-1:0];
            acc_d      = '0;
            cnt_d      = '0;
            byte_cnt_d = '0;
            re_cnt_d   = '0;
            prb_d      = '0;
            state_d    = DATA;
        end else if (i_vld) begin
            case (state_q)
                EXP: begin
                    agc_d      = i_byte[SHIFT_WIDTH-1:0];
                    out_err_d  = i_byte[SHIFT_WIDTH-1:0] > AGC_MAX;
                    byte_cnt_d = '0;
                    state_d    = DATA;
                end
                DATA: begin
                    acc_d = acc_app[HOLD_W-1:0];
                    cnt_d = cnt_app;
                    if (cnt_app >= CNT_W'(RE_BITS)) begin
                        cnt_d     = cnt_app - CNT_W'(RE_BITS);
                        out_vld_d = 1'b1;
                        out_i_d   = re_bits[RE_BITS-1:DATA_WIDTH];
                        out_q_d   = re_bits[DATA_WIDTH-1:0];
                        out_agc_d = agc_q;
                        out_prb_d = prb_q;
                        out_sop_d = (re_cnt_q == '0) && (prb_q == '0);
                        out_eop_d = (re_cnt_q == RE_W'(RE_PER_PRB - 1)) &&
                                    (prb_q == PRB_W'(PRB_NUM - 1));
                        re_cnt_d  = (re_cnt_q == RE_W'(RE_PER_PRB - 1)) ? '0 : re_cnt_q + 1'b1;
                    end
                    if (byte_cnt_q == BYTE_W'(BYTES_PER_PRB - 1)) begin
                        out_err_d  = (cnt_d != '0);
                        acc_d      = '0;
                        cnt_d      = '0;
                        byte_cnt_d = '0;
                        re_cnt_d   = '0;
                        if (prb_q == PRB_W'(PRB_NUM - 1)) begin
                            prb_d   = '0;
                            state_d = IDLE;
                        end else begin
                            prb_d   = prb_q + 1'b1;
                            state_d = EXP;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            agc_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            re_cnt_q   <= '0;
            prb_q      <= '0;
            out_agc_q  <= '0;
            out_i_q    <= '0;
            out_q_q    <= '0;
            out_vld_q  <= 1'b0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            out_prb_q  <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            agc_q      <= agc_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            re_cnt_q   <= re_cnt_d;
            prb_q      <= prb_d;
            out_agc_q  <= out_agc_d;
            out_i_q    <= out_i_d;
            out_q_q    <= out_q_d;
            out_vld_q  <= out_vld_d;
            out_sop_q  <= out_sop_d;
            out_eop_q  <= out_eop_d;
            out_prb_q  <= out_prb_d;
            out_err_q  <= out_err_d;
        end
    end

    assign o_agc     = out_agc_q;
    assign o_dout_i  = out_i_q;
    assign o_dout_q  = out_q_q;
    assign o_vld     = out_vld_q;
    assign o_sop     = out_sop_q;
    assign o_eop     = out_eop_q;
    assign o_prb_idx = out_prb_q;
    assign o_err     = out_err_q;

endmodule

// File: tb/tb_bfp_prb_unpack.sv
// Directed bench for bfp_prb_unpack with a bit-serial reference model feeding an RE scoreboard.
module tb_bfp_prb_unpack;

    localparam int TB_PRB = 2;

    logic       clk;
    logic       rst;
    logic [7:0] i_byte;
    logic       i_vld;
    logic       i_sop;
    logic [3:0] o_agc;
    logic [6:0] o_dout_i;
    logic [6:0] o_dout_q;
    logic       o_vld;
    logic       o_sop;
    logic       o_eop;
    logic [8:0] o_prb_idx;
    logic       o_err;

    bfp_prb_unpack #(
        .SHIFT_WIDTH(4),
        .DATA_WIDTH (7),
        .RE_PER_PRB (12),
        .PRB_NUM    (TB_PRB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_byte   (i_byte),
        .i_vld    (i_vld),
        .i_sop    (i_sop),
        .o_agc    (o_agc),
        .o_dout_i (o_dout_i),
        .o_dout_q (o_dout_q),
        .o_vld    (o_vld),
        .o_sop    (o_sop),
        .o_eop    (o_eop),
        .o_prb_idx(o_prb_idx),
        .o_err    (o_err)
    );

    typedef struct packed {
        logic [3:0] agc;
        logic [6:0] i;
        logic [6:0] q;
        logic       sop;
        logic       eop;
        logic [8:0] prb;
    } re_t;

    re_t exp_q[$];
    bit  bq[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  err_seen = 0;
    int  m_prb = 0;
    int  m_re = 0;
    logic [3:0] m_agc = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: every emitted RE must match the oldest expected one.
    always @(negedge clk) begin
        if (o_err === 1'b1) err_seen++;
        if (o_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_re", 32'(1), 32'(0));
            end else begin
                re_t e;
                e = exp_q.pop_front();
                chk("re_agc", 32'(o_agc), 32'(e.agc));
                chk("re_i", 32'(o_dout_i), 32'(e.i));
                chk("re_q", 32'(o_dout_q), 32'(e.q));
                chk("re_sop", 32'(o_sop), 32'(e.sop));
                chk("re_eop", 32'(o_eop), 32'(e.eop));
                chk("re_prb", 32'(o_prb_idx), 32'(e.prb));
            end
        end
    end

    function automatic logic [7:0] pat(input int k, input int seed);
        logic [7:0] r;
        case (k)
            0: r = 8'h81;
            1: r = 8'h02;
            2: r = 8'h08;
            default: r = 8'(k * 37 + seed);
        endcase
        return r;
    endfunction

    task automatic model_byte(input logic [7:0] b, output logic produced);
        re_t e;
        logic [6:0] iv;
        logic [6:0] qv;
        bit t;
        iv = '0;
        qv = '0;
        for (int k = 7; k >= 0; k--) bq.push_back(b[k]);
        produced = 1'b0;
        if (bq.size() >= 14) begin
            for (int k = 0; k < 7; k++) begin
                t  = bq.pop_front();
                iv = {iv[5:0], t};
            end
            for (int k = 0; k < 7; k++) begin
                t  = bq.pop_front();
                qv = {qv[5:0], t};
            end
            e.agc = m_agc;
            e.i   = iv;
            e.q   = qv;
            e.sop = (m_prb == 0) && (m_re == 0);
            e.eop = (m_prb == TB_PRB - 1) && (m_re == 11);
            e.prb = 9'(m_prb);
            exp_q.push_back(e);
            produced = 1'b1;
            m_re++;
            if (m_re == 12) begin
                m_re = 0;
                m_prb++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic s);
        @(negedge clk);
        i_byte = b;
        i_vld  = 1'b1;
        i_sop  = s;
        @(posedge clk);
        #1;
        i_vld = 1'b0;
        i_sop = 1'b0;
    endtask

    task automatic send_exp(input logic [7:0] b, input logic s, input logic err_exp);
        if (s) begin
            m_prb = 0;
            m_re  = 0;
            bq.delete();
        end
        m_agc = b[3:0];
        send_byte(b, s);
        chk("exp_err", 32'(o_err), 32'(err_exp));
        chk("exp_no_vld", 32'(o_vld), 32'(0));
    endtask

    task automatic send_data(input logic [7:0] b);
        logic produced;
        model_byte(b, produced);
        send_byte(b, 1'b0);
        chk("vld_latency", 32'(o_vld), 32'(produced));
        chk("data_no_err", 32'(o_err), 32'(0));
    endtask

    task automatic send_drop(input logic [7:0] b);
        send_byte(b, 1'b0);
        chk("drop_no_vld", 32'(o_vld), 32'(0));
        chk("drop_no_err", 32'(o_err), 32'(0));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_agc"}, 32'(o_agc), 32'(0));
        chk({tag, "_i"}, 32'(o_dout_i), 32'(0));
        chk({tag, "_q"}, 32'(o_dout_q), 32'(0));
        chk({tag, "_vld"}, 32'(o_vld), 32'(0));
        chk({tag, "_sop"}, 32'(o_sop), 32'(0));
        chk({tag, "_eop"}, 32'(o_eop), 32'(0));
        chk({tag, "_prb"}, 32'(o_prb_idx), 32'(0));
        chk({tag, "_err"}, 32'(o_err), 32'(0));
    endtask

    initial begin
        rst    = 1'b1;
        i_byte = '0;
        i_vld  = 1'b0;
        i_sop  = 1'b0;

        // Traffic during reset has no effect.
        send_byte(8'h13, 1'b1);
        send_byte(8'hFF, 1'b0);
        chk_zero("rst");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) send_drop(8'hFF);

        // Full 2-PRB symbol: all-ones PRB then patterned PRB with gaps.
        send_exp(8'h03, 1'b1, 1'b0);
        for (int k = 0; k < 21; k++) send_data(8'hFF);
        send_exp(8'hF5, 1'b0, 1'b0);
        for (int k = 0; k < 21; k++) begin
            send_data(pat(k, 5));
            if (k % 5 == 2) idle(2);
        end
        for (int k = 0; k < 3; k++) send_drop(8'hA5);
        idle(2);
        chk("symbol1_drained", 32'(exp_q.size()), 32'(0));

        // Out-of-range exponent, then truncation by sop inside PRB 1.
        send_exp(8'hFA, 1'b1, 1'b1);
        for (int k = 0; k < 21; k++) send_data(pat(k, 11));
        send_exp(8'h01, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) send_data(pat(k, 23));
        send_exp(8'h02, 1'b1, 1'b1);
        for (int k = 0; k < 21; k++) send_data(pat(k, 41));
        send_exp(8'h09, 1'b0, 1'b0);
        for (int k = 0; k < 21; k++) begin
            send_data(pat(k, 59));
            if (k == 9) idle(3);
        end
        for (int k = 0; k < 2; k++) send_drop(8'h3C);
        idle(2);
        chk("symbol2_drained", 32'(exp_q.size()), 32'(0));

        // Reset mid-symbol returns to IDLE with nothing pending.
        send_exp(8'h04, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) send_data(pat(k, 77));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        chk("midrst_drained", 32'(exp_q.size()), 32'(0));
        bq.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) send_drop(8'h55);

        idle(3);
        chk("final_drained", 32'(exp_q.size()), 32'(0));
        chk("err_pulses", 32'(err_seen), 32'(2));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
